// File: rtl/v_regfile.sv
// Multi-lane vector register file: els_p registers of vlen_p elements each.
// Per-lane registered reads with write-first bypass, highest-lane-wins write
// collisions with a one-cycle conflict pulse, and a sequential clear engine
// that zeroes one element index of every register per cycle.
module v_regfile #(
    parameter int els_p   = 8,
    parameter int vlen_p  = 8,
    parameter int vdw_p   = 32,
    parameter int lanes_p = 4,
    localparam int reg_width_lp  = (els_p  <= 1) ? 1 : $clog2(els_p),
    localparam int addr_width_lp = (vlen_p <= 1) ? 1 : $clog2(vlen_p)
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic                                     clear_i,
    output logic                                     ready_o,
    input  logic [lanes_p-1:0]                       r_v_i,
    input  logic [lanes_p-1:0][reg_width_lp-1:0]     r_reg_i,
    input  logic [lanes_p-1:0][addr_width_lp-1:0]    r_addr_i,
    output logic [lanes_p-1:0]                       r_v_o,
    output logic [lanes_p-1:0][vdw_p-1:0]            r_data_o,
    input  logic [lanes_p-1:0]                       w_v_i,
    input  logic [lanes_p-1:0][reg_width_lp-1:0]     w_reg_i,
    input  logic [lanes_p-1:0][addr_width_lp-1:0]    w_addr_i,
    input  logic [lanes_p-1:0][vdw_p-1:0]            w_data_i,
    output logic                                     w_conflict_o
);

    typedef enum logic {S_CLEAR, S_READY} state_e;

    // One extra bit so the limits themselves are representable for the compare.
    localparam logic [reg_width_lp:0]    els_lim_lp  = (reg_width_lp + 1)'(els_p);
    localparam logic [addr_width_lp:0]   vlen_lim_lp = (addr_width_lp + 1)'(vlen_p);
    localparam logic [addr_width_lp-1:0] cnt_last_lp = addr_width_lp'(vlen_p - 1);

    function automatic logic reg_ok(input logic [reg_width_lp-1:0] r);
        return {1'b0, r} < els_lim_lp;
    endfunction

    function automatic logic addr_ok(input logic [addr_width_lp-1:0] a);
        return {1'b0, a} < vlen_lim_lp;
    endfunction

    state_e                          state_q, state_d;
    logic [addr_width_lp-1:0]        cnt_q, cnt_d;
    logic                            ready_q, ready_d;
    logic [lanes_p-1:0]              r_v_q, r_v_d;
    logic [lanes_p-1:0][vdw_p-1:0]   r_data_q, r_data_d;
    logic                            w_conflict_q, w_conflict_d;
    logic [vdw_p-1:0]                mem_q [els_p][vlen_p];
    logic [vdw_p-1:0]                mem_d [els_p][vlen_p];
    logic [lanes_p-1:0]              w_ok;

    // Qualify each write lane: array usable and both indices in range.
    always_comb begin
        w_ok = '0;
        for (int i = 0; i < lanes_p; i++) begin
            w_ok[i] = (state_q == S_READY) && w_v_i[i] &&
                      reg_ok(w_reg_i[i]) && addr_ok(w_addr_i[i]);
        end
    end

    // Next array image: lanes applied in ascending order so the highest lane wins;
    // while clearing, zero element cnt of every register instead.
    always_comb begin
        mem_d = mem_q;
        if (state_q == S_READY) begin
            for (int i = 0; i < lanes_p; i++) begin
                if (w_ok[i]) begin
                    mem_d[w_reg_i[i]][w_addr_i[i]] = w_data_i[i];
                end
            end
        end else begin
            for (int r = 0; r < els_p; r++) begin
                mem_d[r][cnt_q] = '0;
            end
        end
    end

    // Collision detect: any pair of qualified lanes hitting the same reg/addr.
    always_comb begin
        w_conflict_d = 1'b0;
        for (int i = 0; i < lanes_p; i++) begin
            for (int j = i + 1; j < lanes_p; j++) begin
                if (w_ok[i] && w_ok[j] && (w_reg_i[i] == w_reg_i[j]) &&
                    (w_addr_i[i] == w_addr_i[j])) begin
                    w_conflict_d = 1'b1;
                end
            end
        end
    end

    // Reads sample the post-write image, which gives write-first bypass for free.
    always_comb begin
        r_v_d    = '0;
        r_data_d = r_data_q;
        if (state_q == S_READY) begin
            for (int i = 0; i < lanes_p; i++) begin
                if (r_v_i[i]) begin
                    r_v_d[i] = 1'b1;
                    if (reg_ok(r_reg_i[i]) && addr_ok(r_addr_i[i])) begin
                        r_data_d[i] = mem_d[r_reg_i[i]][r_addr_i[i]];
                    end else begin
                        r_data_d[i] = '0;
                    end
                end
            end
        end else begin
            r_data_d = '0;
        end
    end

    // Clear/ready sequencing: vlen_p clear cycles, then usable until clear_i.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        if (state_q == S_CLEAR) begin
            if (cnt_q == cnt_last_lp) begin
                state_d = S_READY;
                ready_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (clear_i) begin
            state_d = S_CLEAR;
            ready_d = 1'b0;
            cnt_d   = '0;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= S_CLEAR;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            r_v_q        <= '0;
            r_data_q     <= '0;
            w_conflict_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            r_v_q        <= r_v_d;
            r_data_q     <= r_data_d;
            w_conflict_q <= w_conflict_d;
        end
    end

    // Storage array; contents are initialised by the clear engine, not by reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign ready_o      = ready_q;
    assign r_v_o        = r_v_q;
    assign r_data_o     = r_data_q;
    assign w_conflict_o = w_conflict_q;

endmodule
